clk_div_mon: RTL and testbench
==============================

# clk_div_mon

Clock-divider monitor: samples a divided clock (for example the output of the team's odd-ratio dividers) in the source clock domain, measures its period and high time in source-clock cycles, and declares lock once consecutive measurements match the expected ratio. It sits beside each divider instance as the checking end of the divide path. Its status feeds clock-health logic and the bench scoreboard.

## Interface
- EXP_DIV, 9: expected division ratio; integer, 2 or greater
- CNT_W, 8: counter and result width; must satisfy 2^CNT_W > 2*EXP_DIV
- LOCK_CNT, 4: consecutive good measurements required to assert lock; 1 to 15
- clk  in  1: source (undivided) clock; all logic on posedge
- rstn  in  1: reset, synchronous, active-low
- div_in  in  1: divided clock under test; treated as asynchronous
- period  out  CNT_W: last measured rise-to-rise period, in clk cycles
- high_time  out  CNT_W: high-cycle count of the last completed period
- meas_vld  out  1: one-cycle pulse when period and high_time update
- locked  out  1: level; ratio confirmed
- err  out  1: one-cycle pulse on a bad measurement or a timeout

## Operation
- div_in passes through a 2-flop synchronizer to give s; a third flop gives s_d; rise = s & ~s_d.
- States are IDLE and MEAS. Reset enters IDLE.
- IDLE:
  - On rise: cnt <= 1, hcnt <= 1, go to MEAS.
  - No measurement is reported in IDLE.
- MEAS, on a cycle without rise:
  - cnt <= cnt+1.
  - hcnt <= hcnt+s.
- MEAS, on rise:
  - period <= cnt, high_time <= hcnt, meas_vld pulses.
  - Then cnt <= 1, hcnt <= 1.
- A measurement is good when period == EXP_DIV and high_time is in {EXP_DIV>>1, (EXP_DIV>>1)+1}. The two-value window covers the half-cycle skew of odd-ratio divided clocks.
- On a good measurement: gcnt increments, saturating at LOCK_CNT. locked <= 1 when gcnt reaches LOCK_CNT.
- On a bad measurement: gcnt <= 0, locked <= 0, err pulses. The state stays MEAS.
- Timeout: in MEAS, if cnt == 2*EXP_DIV and there is no rise, then err pulses, locked <= 0, gcnt <= 0, and the state returns to IDLE. period and high_time hold their values.
- Simultaneous rise and cnt == 2*EXP_DIV: the rise is processed as a normal (bad) measurement, and no separate timeout is raised.
- Reset values: period 0, high_time 0, meas_vld 0, locked 0, err 0. Synchronizer flops, cnt, hcnt and gcnt are all 0.
- Reset asserted mid-measurement discards the measurement in progress and clears lock on the next clk edge.

## Timing
- Latency from a div_in rising transition to rise is 2–3 clk cycles (synchronizer plus edge flop).
- meas_vld, period, high_time and err update on the clk edge after rise and are registered.
- locked changes in the same cycle as the meas_vld that completes the LOCK_CNT-th good measurement.
- The first meas_vld comes one full period after the first rise following reset. A steady correct input therefore locks after (LOCK_CNT+1)*EXP_DIV + 3 cycles at most.
- meas_vld and err are never asserted for more than one cycle per event.
- meas_vld and err are asserted in the same cycle on a bad measurement.

## Configuration
- CLK_DIV_MON_DUTY_EN defined:
  - hcnt is implemented.
  - high_time carries the high-cycle count.
  - The goodness test includes the high-time window.
- CLK_DIV_MON_DUTY_EN undefined:
  - hcnt is removed.
  - high_time is tied to 0.
  - A measurement is good on period == EXP_DIV alone.

## Structure
- Package clk_div_pkg holds:
  - the state typedef (IDLE, MEAS);
  - the derived localparams TMO_CNT = 2*EXP_DIV, HI_LO = EXP_DIV>>1 and HI_HI = (EXP_DIV>>1)+1, defined as functions of EXP_DIV.
- One sub-module, clk_sync2: a 2-flop synchronizer with synchronous active-low reset to 0. It is instanced once for div_in and is reusable by other blocks.
- Counters, state machine and lock logic stay in clk_div_mon.

## Test plan
- Ideal div-9 clock, 5 high / 4 low, defaults: meas_vld every 9 cycles with period 9 and high_time 5; locked rises on the 4th meas_vld; err never asserts.
- Div-9 clock with half-cycle duty (posedge/negedge AND style, 4.5 high): high_time 4 or 5; locked reaches 1; no err.
- Locked, then one period stretched to 10 cycles: meas_vld with period 10, err pulse in the same cycle, locked drops; relock after 4 further good periods.
- Locked, then div_in held low: err pulse when cnt reaches 18, locked 0, state IDLE; resuming the clock gives its first meas_vld one period after the first rise.
- rstn pulsed low for one cycle while locked mid-period: next cycle period, high_time and locked are all 0; no meas_vld until two rises after release.
- Build without CLK_DIV_MON_DUTY_EN, feed a div-9 clock at 2 high / 7 low: locked reaches 1, high_time stays 0, no err.

Source files
------------

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared types and derived-constant helpers for the clock
//               divider monitor (state encoding, timeout and high-time
//               window limits expressed as functions of the expected ratio).
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  // Monitor states: waiting for the first edge, or timing a period.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  // A missing edge is declared after twice the expected period.
  function automatic int tmo_cnt(input int exp_div);
    return 2 * exp_div;
  endfunction

  // Lower bound of the accepted high time (floor of half the period).
  function automatic int hi_lo(input int exp_div);
    return exp_div >> 1;
  endfunction

  // Upper bound of the accepted high time; odd ratios may land either side.
  function automatic int hi_hi(input int exp_div);
    return (exp_div >> 1) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_mon_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_mon_if
// Description : Divided-clock input and measurement/status outputs of the
//               clock divider monitor. The master modport is the monitor,
//               the slave modport is whoever drives the divided clock and
//               consumes the status.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_mon_if #(
  parameter int CNT_W = 8
);
  logic             div_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_vld;
  logic             locked;
  logic             err;

  modport master (
    input  div_in,
    output period,
    output high_time,
    output meas_vld,
    output locked,
    output err
  );

  modport slave (
    output div_in,
    input  period,
    input  high_time,
    input  meas_vld,
    input  locked,
    input  err
  );
endinterface
`default_nettype wire

// File: rtl/clk_sync2.sv
`default_nettype none
// ============================================================================
// Module      : clk_sync2
// Description : Two-flop synchronizer for a single asynchronous bit, with a
//               synchronous active-low reset to 0. Reusable by any block.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops give metastability time before use.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/clk_div_mon.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_mon
// Description : Divided-clock monitor. Synchronizes div_in, measures its
//               rise-to-rise period and high time in clk cycles, flags bad
//               measurements and missing edges, and asserts locked after
//               LOCK_CNT consecutive good measurements.
//               Optional macro CLK_DIV_MON_DUTY_EN: when defined, the high
//               time is counted and checked against a two-value window;
//               when undefined, high_time reads 0 and only the period counts.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_mon
  import clk_div_pkg::*;
#(
  parameter int EXP_DIV  = 9,  // expected ratio, >= 2
  parameter int CNT_W    = 8,  // 2**CNT_W must exceed 2*EXP_DIV
  parameter int LOCK_CNT = 4   // 1..15
) (
  input  logic          clk,
  input  logic          rstn,
  clk_div_mon_if.master mon
);

  localparam logic [CNT_W-1:0] c_EXP_DIV  = CNT_W'(EXP_DIV);
  localparam logic [CNT_W-1:0] c_TMO_CNT  = CNT_W'(tmo_cnt(EXP_DIV));
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
  localparam logic [3:0]       c_LOCK_CNT = 4'(LOCK_CNT);

  logic             w_s;
  logic             r_s_d;
  logic             w_rise;
  logic             w_good;
  logic [3:0]       w_gcnt_nxt;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [3:0]       r_gcnt;
  logic             r_meas_vld;
  logic             r_locked;
  logic             r_err;

`ifdef CLK_DIV_MON_DUTY_EN
  localparam logic [CNT_W-1:0] c_HI_LO = CNT_W'(hi_lo(EXP_DIV));
  localparam logic [CNT_W-1:0] c_HI_HI = CNT_W'(hi_hi(EXP_DIV));
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_high_time;
`endif

  clk_sync2 u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (mon.div_in),
    .q    (w_s)
  );

  // Edge flop behind the synchronizer for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s_d <= 1'b0;
    end else begin
      r_s_d <= w_s;
    end
  end

  assign w_rise = w_s & ~r_s_d;

  // Goodness of the measurement completing on this rise, plus the
  // saturating next value of the good-measurement counter.
  always_comb begin
    w_good = 1'b0;
`ifdef CLK_DIV_MON_DUTY_EN
    w_good = (r_cnt == c_EXP_DIV) &&
             ((r_hcnt == c_HI_LO) || (r_hcnt == c_HI_HI));
`else
    w_good = (r_cnt == c_EXP_DIV);
`endif
    w_gcnt_nxt = (r_gcnt >= c_LOCK_CNT) ? r_gcnt : r_gcnt + 4'd1;
  end

  // Measurement state machine: counters, results, lock and error pulses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_gcnt     <= '0;
      r_period   <= '0;
      r_meas_vld <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
`ifdef CLK_DIV_MON_DUTY_EN
      r_hcnt      <= '0;
      r_high_time <= '0;
`endif
    end else begin
      r_meas_vld <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          // The first rise only opens a period; nothing to report yet.
          if (w_rise) begin
            r_cnt   <= c_ONE;
`ifdef CLK_DIV_MON_DUTY_EN
            r_hcnt  <= c_ONE;
`endif
            r_state <= MEAS;
          end
        end
        MEAS: begin
          if (w_rise) begin
            // A rise wins over a coincident timeout: it is a measurement.
            r_period   <= r_cnt;
            r_meas_vld <= 1'b1;
            r_cnt      <= c_ONE;
`ifdef CLK_DIV_MON_DUTY_EN
            r_high_time <= r_hcnt;
            r_hcnt      <= c_ONE;
`endif
            if (w_good) begin
              r_gcnt <= w_gcnt_nxt;
              if (w_gcnt_nxt == c_LOCK_CNT) begin
                r_locked <= 1'b1;
              end
            end else begin
              r_gcnt   <= '0;
              r_locked <= 1'b0;
              r_err    <= 1'b1;
            end
          end else if (r_cnt == c_TMO_CNT) begin
            // Edge missing for two nominal periods: drop lock and rearm.
            r_err    <= 1'b1;
            r_locked <= 1'b0;
            r_gcnt   <= '0;
            r_state  <= IDLE;
          end else begin
            r_cnt  <= r_cnt + c_ONE;
`ifdef CLK_DIV_MON_DUTY_EN
            r_hcnt <= r_hcnt + {{(CNT_W-1){1'b0}}, w_s};
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mon.period   = r_period;
  assign mon.meas_vld = r_meas_vld;
  assign mon.locked   = r_locked;
  assign mon.err      = r_err;
`ifdef CLK_DIV_MON_DUTY_EN
  assign mon.high_time = r_high_time;
`else
  assign mon.high_time = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_mon.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_mon
// Description : Directed self-checking bench for clk_div_mon (EXP_DIV 9,
//               LOCK_CNT 4). Honours CLK_DIV_MON_DUTY_EN for the expected
//               high-time results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_mon;

`ifdef CLK_DIV_MON_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  clk_div_mon_if #(.CNT_W(8)) mif ();

  clk_div_mon #(
    .EXP_DIV  (9),
    .CNT_W    (8),
    .LOCK_CNT (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .mon  (mif)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Observation log, sampled on the falling edge.
  int cyc = 0, n_vld = 0, n_err = 0, n_err_solo = 0, n_dbl = 0, last_err_cyc = 0;
  int v_per[256], v_ht[256], v_lock[256], v_err[256], v_cyc[256];
  logic p_vld = 1'b0, p_err = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mif.meas_vld) begin
      if (n_vld < 256) begin
        v_per[n_vld]  = int'(mif.period);
        v_ht[n_vld]   = int'(mif.high_time);
        v_lock[n_vld] = int'(mif.locked);
        v_err[n_vld]  = int'(mif.err);
        v_cyc[n_vld]  = cyc;
      end
      n_vld++;
    end
    if (mif.err) begin
      n_err++;
      last_err_cyc = cyc;
      if (!mif.meas_vld) n_err_solo++;
    end
    if ((mif.meas_vld && p_vld) || (mif.err && p_err)) n_dbl++;
    p_vld = mif.meas_vld;
    p_err = mif.err;
  end

  task automatic hold(input logic v, input int n);
    mif.div_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic per(input int h, input int l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  int b, e0, s0, ok;

  initial begin
    mif.div_in = 1'b0;
    rstn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_val("rst_period", int'(mif.period), 0);
    check_val("rst_high_time", int'(mif.high_time), 0);
    check_val("rst_meas_vld", int'(mif.meas_vld), 0);
    check_val("rst_locked", int'(mif.locked), 0);
    check_val("rst_err", int'(mif.err), 0);
    rstn = 1'b1;
    hold(1'b0, 5);

    // Ideal div-9, 5 high / 4 low: 6 rises give 5 measurements.
    b = n_vld;
    repeat (6) per(5, 4);
    check_val("t1_nvld", n_vld - b, 5);
    ok = 0;
    for (int i = 0; i < 5; i++)
      if (v_per[b+i] == 9 && v_ht[b+i] == (DUTY ? 5 : 0)) ok++;
    check_val("t1_per_ht_ok", ok, 5);
    check_val("t1_gap", v_cyc[b+1] - v_cyc[b], 9);
    check_val("t1_lock_3rd", v_lock[b+2], 0);
    check_val("t1_lock_4th", v_lock[b+3], 1);
    check_val("t1_no_err", n_err, 0);

    // One stretched period of 10, then relock after 4 good ones.
    b = n_vld; e0 = n_err;
    per(5, 5);
    repeat (5) per(5, 4);
    check_val("t3_nvld", n_vld - b, 6);
    check_val("t3_lock_before", v_lock[b], 1);
    check_val("t3_per10", v_per[b+1], 10);
    check_val("t3_err_with_vld", v_err[b+1], 1);
    check_val("t3_lock_drop", v_lock[b+1], 0);
    check_val("t3_lock_3good", v_lock[b+4], 0);
    check_val("t3_relock", v_lock[b+5], 1);
    check_val("t3_err_cnt", n_err - e0, 1);

    // div_in stuck low: timeout 18 cycles after the last measurement.
    b = n_vld; e0 = n_err; s0 = n_err_solo;
    hold(1'b0, 30);
    check_val("t4_err_cnt", n_err - e0, 1);
    check_val("t4_err_solo", n_err_solo - s0, 1);
    check_val("t4_tmo_cyc", last_err_cyc - v_cyc[b-1], 18);
    check_val("t4_locked", int'(mif.locked), 0);
    check_val("t4_no_vld", n_vld - b, 0);
    // Resume: back in IDLE, so 3 rises give only 2 measurements.
    b = n_vld;
    repeat (3) per(5, 4);
    check_val("t4_resume_nvld", n_vld - b, 2);
    check_val("t4_resume_per", v_per[b], 9);

    // Relock, then reset during the low phase of a period.
    repeat (3) per(5, 4);
    check_val("t5_locked", int'(mif.locked), 1);
    hold(1'b1, 5);
    hold(1'b0, 2);
    e0 = n_err;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check_val("t5_rst_period", int'(mif.period), 0);
    check_val("t5_rst_high_time", int'(mif.high_time), 0);
    check_val("t5_rst_locked", int'(mif.locked), 0);
    hold(1'b0, 2);
    b = n_vld;
    per(5, 4);
    check_val("t5_no_vld_1rise", n_vld - b, 0);
    per(5, 4);
    check_val("t5_vld_2rise", n_vld - b, 1);
    check_val("t5_per", v_per[b], 9);
    check_val("t5_no_err", n_err - e0, 0);

    // Half-cycle duty: high changes on the falling clock edge.
    b = n_vld; e0 = n_err;
    repeat (6) begin
      mif.div_in = 1'b1;
      #45;
      mif.div_in = 1'b0;
      #45;
    end
    check_val("t2_nvld", n_vld - b, 6);
    ok = 0;
    for (int i = 1; i < 6; i++)
      if (v_per[b+i] == 9 &&
          (DUTY ? (v_ht[b+i] == 4 || v_ht[b+i] == 5) : (v_ht[b+i] == 0))) ok++;
    check_val("t2_per_ht_ok", ok, 5);
    check_val("t2_locked", int'(mif.locked), 1);
    check_val("t2_no_err", n_err - e0, 0);

    // 2 high / 7 low: good without duty checking, bad with it.
    b = n_vld; e0 = n_err;
    repeat (6) per(2, 7);
    check_val("t6_nvld", n_vld - b, 6);
    check_val("t6_per", v_per[b+5], 9);
    check_val("t6_ht", v_ht[b+5], DUTY ? 2 : 0);
    check_val("t6_err_cnt", n_err - e0, DUTY ? 5 : 0);
    check_val("t6_locked", int'(mif.locked), DUTY ? 0 : 1);

    check_val("single_cycle_pulses", n_dbl, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
